// File: rtl/ow_byte_engine_if.sv
// Command/result bundle between the SPI command decoder and the 1-Wire byte engine.
interface ow_byte_engine_if;
  logic       reset_req;
  logic       write_req;
  logic       read_req;
  logic [7:0] tx_byte;
  logic       busy;
  logic       done;
  logic       presence;
  logic [7:0] rx_byte;

  modport master (
    output reset_req, write_req, read_req, tx_byte,
    input  busy, done, presence, rx_byte
  );

  modport slave (
    input  reset_req, write_req, read_req, tx_byte,
    output busy, done, presence, rx_byte
  );
endinterface

// File: rtl/ow_byte_engine.sv
// 1-Wire bus master: reset/presence, LSB-first byte write and byte read on DQ,
// timed from an internal 1 us tick.
module ow_byte_engine #(
  parameter int unsigned CLKS_PER_US   = 25,
  parameter int unsigned T_RST_LOW     = 480,
  parameter int unsigned T_PRES_SAMPLE = 70,
  parameter int unsigned T_RST_TOTAL   = 960,
  parameter int unsigned T_SLOT        = 70,
  parameter int unsigned T_LOW1        = 6,
  parameter int unsigned T_LOW0        = 60,
  parameter int unsigned T_RD_SAMPLE   = 15
) (
  input  logic              clk,
  input  logic              n_rst,
  ow_byte_engine_if.slave   cmd,
  output logic              wire_out,
  input  logic              wire_in
);

  typedef enum logic [2:0] {
    IDLE, RST_LOW, RST_WAIT, SLOT_LOW, SLOT_REL, DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_RST, OP_WR, OP_RD
  } op_t;

  // Compare against end-1 on a tick so the state changes on the same edge
  // that us_cnt reaches the spec'd microsecond value.
  localparam logic [7:0] PRESC_MAX   = 8'(CLKS_PER_US - 1);
  localparam logic [9:0] RST_LOW_END = 10'(T_RST_LOW - 1);
  localparam logic [9:0] PRES_PT     = 10'(T_RST_LOW + T_PRES_SAMPLE - 1);
  localparam logic [9:0] RST_END     = 10'(T_RST_TOTAL - 1);
  localparam logic [9:0] LOW1_END    = 10'(T_LOW1 - 1);
  localparam logic [9:0] LOW0_END    = 10'(T_LOW0 - 1);
  localparam logic [9:0] RD_PT       = 10'(T_RD_SAMPLE - 1);
  localparam logic [9:0] SLOT_END    = 10'(T_SLOT - 1);

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [7:0]  presc_q, presc_d;
  logic [9:0]  us_cnt_q, us_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        presence_q, presence_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic [1:0]  sync_q, sync_d;

  logic        tick;
  logic        wire_sync;
  logic [9:0]  low_end;

  assign tick      = (presc_q == PRESC_MAX);
  assign wire_sync = sync_q[1];
  assign low_end   = (op_q == OP_WR && !shift_q[0]) ? LOW0_END : LOW1_END;
  assign sync_d    = {sync_q[0], wire_in};

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    presc_d    = presc_q;
    us_cnt_d   = us_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    presence_d = presence_q;
    rx_byte_d  = rx_byte_q;

    if (state_q != IDLE) begin
      presc_d = tick ? 8'd0 : presc_q + 8'd1;
      if (tick) begin
        us_cnt_d = us_cnt_q + 10'd1;
      end
    end

    case (state_q)
      IDLE: begin
        presc_d   = 8'd0;
        us_cnt_d  = 10'd0;
        bit_cnt_d = 3'd0;
        if (cmd.reset_req) begin
          op_d    = OP_RST;
          state_d = RST_LOW;
        end else if (cmd.write_req) begin
          op_d    = OP_WR;
          shift_d = cmd.tx_byte;
          state_d = SLOT_LOW;
        end else if (cmd.read_req) begin
          op_d    = OP_RD;
          shift_d = 8'h00;
          state_d = SLOT_LOW;
        end
      end

      RST_LOW: begin
        if (tick && us_cnt_q == RST_LOW_END) begin
          state_d = RST_WAIT;
        end
      end

      RST_WAIT: begin
        if (tick && us_cnt_q == PRES_PT) begin
          presence_d = ~wire_sync;
        end
        if (tick && us_cnt_q == RST_END) begin
          state_d = DONE;
        end
      end

      SLOT_LOW: begin
        if (tick && us_cnt_q == low_end) begin
          state_d = SLOT_REL;
        end
      end

      SLOT_REL: begin
        if (op_q == OP_RD && tick && us_cnt_q == RD_PT) begin
          shift_d = {wire_sync, shift_q[7:1]};
        end
        if (tick && us_cnt_q == SLOT_END) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (op_q == OP_WR) begin
            shift_d = {1'b0, shift_q[7:1]};
          end
          if (bit_cnt_q == 3'd7) begin
            state_d = DONE;
            // The last read sample is already in, so rx_byte is valid during DONE.
            if (op_q == OP_RD) begin
              rx_byte_d = shift_q;
            end
          end else begin
            state_d  = SLOT_LOW;
            us_cnt_d = 10'd0;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      op_q       <= OP_RST;
      presc_q    <= 8'd0;
      us_cnt_q   <= 10'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      presence_q <= 1'b0;
      rx_byte_q  <= 8'h00;
      sync_q     <= 2'b11;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      presc_q    <= presc_d;
      us_cnt_q   <= us_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      presence_q <= presence_d;
      rx_byte_q  <= rx_byte_d;
      sync_q     <= sync_d;
    end
  end

  // Decoded from state so an asynchronous reset releases the line at once.
  assign wire_out     = ~((state_q == RST_LOW) || (state_q == SLOT_LOW));
  assign cmd.busy     = (state_q != IDLE);
  assign cmd.done     = (state_q == DONE);
  assign cmd.presence = presence_q;
  assign cmd.rx_byte  = rx_byte_q;

endmodule

// File: tb/tb_ow_byte_engine.sv
// Self-checking bench for ow_byte_engine: vector table, hand-written corner
// sequences and random operations against a microsecond-level reference model.
module tb_ow_byte_engine;

  localparam int CPU           = 4;
  localparam int T_RST_LOW     = 480;
  localparam int T_PRES_SAMPLE = 70;
  localparam int T_RST_TOTAL   = 960;
  localparam int T_SLOT        = 70;
  localparam int T_LOW1        = 6;
  localparam int T_LOW0        = 60;
  localparam int T_RD_SAMPLE   = 15;
  localparam int LIMIT         = 2 * T_RST_TOTAL * CPU + 100;

  localparam int K_RST = 0, K_WR = 1, K_RD = 2;
  localparam int DEV_NONE = 0, DEV_PRES = 1, DEV_READ = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         dev;
    logic [7:0] dev_byte;
    logic       exp_presence;
    logic [7:0] exp_rx;
  } vec_t;

  logic clk;
  logic n_rst;
  logic wire_out;
  logic wire_in;
  logic dev_pull;

  ow_byte_engine_if bus();

  ow_byte_engine #(
    .CLKS_PER_US   (CPU),
    .T_RST_LOW     (T_RST_LOW),
    .T_PRES_SAMPLE (T_PRES_SAMPLE),
    .T_RST_TOTAL   (T_RST_TOTAL),
    .T_SLOT        (T_SLOT),
    .T_LOW1        (T_LOW1),
    .T_LOW0        (T_LOW0),
    .T_RD_SAMPLE   (T_RD_SAMPLE)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .cmd      (bus),
    .wire_out (wire_out),
    .wire_in  (wire_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign wire_in = wire_out & ~dev_pull;

  int         n_cmp = 0;
  int         n_fail = 0;
  int         lows[$];
  int         exp_lows[$];
  int         run_len = 0;
  int         done_cnt = 0;
  int         dev_mode = DEV_NONE;
  logic [7:0] dev_data = 8'h00;
  int         dev_idx = 0;
  logic       mdl_presence = 1'b0;
  logic [7:0] mdl_rx = 8'h00;
  vec_t       vecs[10];

  // Slave device: presence pulse 15..240 us after reset release, or
  // holds the line low until 30 us into a read slot for each 0 bit.
  initial dev_pull = 1'b0;
  always begin
    @(negedge wire_out);
    if (dev_mode == DEV_PRES) begin
      @(posedge wire_out);
      repeat (15 * CPU) @(negedge clk);
      dev_pull = 1'b1;
      repeat (225 * CPU) @(negedge clk);
      dev_pull = 1'b0;
    end else if (dev_mode == DEV_READ) begin
      if (!dev_data[dev_idx]) begin
        dev_pull = 1'b1;
        repeat (30 * CPU) @(negedge clk);
        dev_pull = 1'b0;
      end
      dev_idx = (dev_idx + 1) % 8;
    end
  end

  always begin
    @(negedge clk);
    if (!wire_out) begin
      run_len++;
    end else if (run_len > 0) begin
      lows.push_back(run_len);
      run_len = 0;
    end
    if (bus.done === 1'b1) done_cnt++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  // Called at a negedge with the engine idle; returns at the negedge after done.
  task automatic applyStimulus(input int kind, input logic [7:0] data, input int dev,
                               input logic [7:0] dev_byte, input bit stacked);
    int cyc;
    int exp_cyc;
    exp_lows.delete();
    if (kind == K_RST) begin
      exp_cyc = T_RST_TOTAL * CPU + 1;
      exp_lows.push_back(T_RST_LOW * CPU);
      mdl_presence = (dev == DEV_PRES);
    end else begin
      exp_cyc = 8 * T_SLOT * CPU + 1;
      for (int i = 0; i < 8; i++)
        exp_lows.push_back((kind == K_WR && !data[i]) ? T_LOW0 * CPU : T_LOW1 * CPU);
      if (kind == K_RD) mdl_rx = (dev == DEV_READ) ? dev_byte : 8'hFF;
    end

    lows.delete();
    done_cnt = 0;
    dev_mode = dev;
    dev_data = dev_byte;
    dev_idx  = 0;
    bus.tx_byte   = data;
    bus.reset_req = (kind == K_RST);
    bus.write_req = (kind == K_WR);
    bus.read_req  = (kind == K_RD) || stacked;
    @(negedge clk);
    bus.reset_req = 1'b0;
    bus.write_req = 1'b0;
    bus.read_req  = 1'b0;
    cyc = 1;
    checkOutput("busy_after_accept", bus.busy, 1);
    while (bus.done !== 1'b1 && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      bus.write_req = stacked && (cyc == 100 * CPU);
      if (stacked) bus.tx_byte = 8'($urandom);
    end
    bus.write_req = 1'b0;
    checkOutput("op_cycles", cyc, exp_cyc);
    checkOutput("busy_at_done", bus.busy, 1);
    checkOutput("presence", bus.presence, mdl_presence);
    checkOutput("rx_byte", bus.rx_byte, mdl_rx);
    @(negedge clk);
    checkOutput("busy_after_done", bus.busy, 0);
    checkOutput("done_pulses", done_cnt, 1);
    checkOutput("low_pulse_count", lows.size(), exp_lows.size());
    for (int i = 0; i < exp_lows.size() && i < lows.size(); i++)
      checkOutput($sformatf("low_width[%0d]", i), lows[i], exp_lows[i]);
    dev_mode = DEV_NONE;
  endtask

  initial begin
    vecs[0] = '{K_RD,  8'h00, DEV_READ, 8'h5A, 1'b0, 8'h5A};
    vecs[1] = '{K_RST, 8'h00, DEV_PRES, 8'h00, 1'b1, 8'h5A};
    vecs[2] = '{K_RST, 8'h00, DEV_NONE, 8'h00, 1'b0, 8'h5A};
    vecs[3] = '{K_RST, 8'h00, DEV_PRES, 8'h00, 1'b1, 8'h5A};
    vecs[4] = '{K_WR,  8'hA5, DEV_NONE, 8'h00, 1'b1, 8'h5A};
    vecs[5] = '{K_RD,  8'h00, DEV_READ, 8'hC3, 1'b1, 8'hC3};
    vecs[6] = '{K_WR,  8'h3C, DEV_NONE, 8'h00, 1'b1, 8'hC3};
    vecs[7] = '{K_RST, 8'h00, DEV_NONE, 8'h00, 1'b0, 8'hC3};
    vecs[8] = '{K_RD,  8'h00, DEV_NONE, 8'h00, 1'b0, 8'hFF};
    vecs[9] = '{K_RD,  8'h00, DEV_READ, 8'h00, 1'b0, 8'h00};

    n_rst = 1'b0;
    bus.reset_req = 1'b0;
    bus.write_req = 1'b0;
    bus.read_req  = 1'b0;
    bus.tx_byte   = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_wire_out", wire_out, 1);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_done", bus.done, 0);
    checkOutput("reset_presence", bus.presence, 0);
    checkOutput("reset_rx_byte", bus.rx_byte, 8'h00);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Abort a write 300 us in, while bit 4 (a 0) is being driven low.
    done_cnt = 0;
    bus.tx_byte   = 8'hA5;
    bus.write_req = 1'b1;
    @(negedge clk);
    bus.write_req = 1'b0;
    repeat (300 * CPU - 1) @(negedge clk);
    checkOutput("abort_line_low_before", wire_out, 0);
    #2 n_rst = 1'b0;
    #1;
    checkOutput("abort_wire_release", wire_out, 1);
    checkOutput("abort_busy", bus.busy, 0);
    checkOutput("abort_done", bus.done, 0);
    checkOutput("abort_rx_byte", bus.rx_byte, 8'h00);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("abort_no_done", done_cnt, 0);
    checkOutput("abort_stays_idle", bus.busy, 0);

    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].kind, vecs[v].data, vecs[v].dev, vecs[v].dev_byte, 1'b0);
      checkOutput($sformatf("vec%0d_presence", v), bus.presence, vecs[v].exp_presence);
      checkOutput($sformatf("vec%0d_rx_byte", v), bus.rx_byte, vecs[v].exp_rx);
    end

    // Reset and read together, then a write pulsed while busy: only the reset runs.
    applyStimulus(K_RST, 8'h77, DEV_PRES, 8'h00, 1'b1);
    checkOutput("stacked_rx_unchanged", bus.rx_byte, 8'h00);

    for (int r = 0; r < 5; r++) begin
      int         kind;
      int         dev;
      logic [7:0] data;
      logic [7:0] db;
      kind = $urandom_range(0, 2);
      data = 8'($urandom);
      db   = 8'($urandom);
      if (kind == K_RST)     dev = ($urandom_range(0, 1) == 1) ? DEV_PRES : DEV_NONE;
      else if (kind == K_RD) dev = DEV_READ;
      else                   dev = DEV_NONE;
      applyStimulus(kind, data, dev, db, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
